cov_sum_accum: RTL and testbench
================================

Name: cov_sum_accum

Overview:
- Coverage accumulator feeding the coverage monitor and the fuzz coverage collector.
- Takes a per-cycle vector of raw coverage-point hits from the DUT instrumentation and keeps a sticky "seen" bitmap.
- Counts first-time hits only, and produces the running unique-coverage total (covSum) that the stall monitor compares cycle to cycle.
- Provides a snapshot handshake that returns a drained, stable total to the harness at round end, and a clear that restarts accounting for each fuzz round.

Parameters:
- NUM_POINTS, 64, number of coverage points, i.e. width of cov_hit; legal range 8..1024, multiple of 8.
- COV_WIDTH, 30, width of cov_sum and snap_sum.
- CNT_W, $clog2(NUM_POINTS+1), width of the per-cycle new-hit count (derived; not overridden).

Ports:
- clock  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cov_valid  input  1  cov_hit is meaningful this cycle.
- cov_hit  input  NUM_POINTS  raw hit bits, one per coverage point.
- clear  input  1  synchronous round restart; clears all accounting.
- snap_req  input  1  request a drained snapshot of the total.
- snap_ack  output  1  one-cycle pulse: snap_sum is valid.
- snap_sum  output  COV_WIDTH  snapshot value; held until the next ack.
- cov_sum  output  COV_WIDTH  live unique-hit total.
- new_hit  output  1  high in any cycle the count stage is nonzero.
- saturated  output  1  sticky: cov_sum reached all-ones.

Behaviour:
- Reset (async):
  - seen, stage registers, cov_sum, snap_sum, snap_ack, new_hit and saturated all go to 0.
  - FSM goes to IDLE.
- Stage S1 (edge closing cycle n):
  - new_mask <= cov_valid ? (cov_hit & ~seen) : 0.
  - seen <= seen | (cov_valid ? cov_hit : 0).
  - Duplicate bits presented in one cycle, or a point hit in back-to-back cycles, count once.
- Stage S2:
  - cnt <= popcount(new_mask), CNT_W bits.
  - Popcount is a sum of NUM_POINTS/8 byte popcounts; a single-cycle adder tree is acceptable.
  - new_hit is driven from the registered cnt != 0.
- Stage S3: cov_sum <= min(cov_sum + cnt, 2^COV_WIDTH-1).
  - Saturating; saturated sets on reaching all-ones and stays set until clear or reset.
- Latency: a hit presented in cycle n is reflected in cov_sum from cycle n+3. Throughput is one vector per cycle with no backpressure.
- clear:
  - In the cycle it is high, the next edge zeroes seen, new_mask, cnt, cov_sum and saturated.
  - Hits presented in the clear cycle are dropped, not recorded in seen.
  - Clear has priority over everything. snap_sum is not cleared.
- Snapshot FSM, states IDLE, DRAIN1, DRAIN2, ACK:
  - IDLE: snap_req=1 goes to DRAIN1.
  - DRAIN1 goes to DRAIN2; DRAIN2 goes to ACK.
  - ACK: snap_ack=1 and snap_sum <= cov_sum (registered in the same edge, so snap_sum is valid together with the ack), then return to IDLE.
  - Result: for snap_req in cycle n, snap_ack is in cycle n+3, and snap_sum includes exactly the hits presented up to and including cycle n, plus those in n+1..n+2 that are already counted in S3.
  - Hits after n continue to accumulate in cov_sum.
  - snap_req outside IDLE is ignored, with no queueing.
  - clear in DRAIN1/DRAIN2/ACK aborts to IDLE with no ack; snap_sum is unchanged.
  - snap_req together with clear is ignored.
- Reset mid-operation: the asynchronous reset dominates. An in-flight snapshot is lost and no ack is issued.
- cov_sum is monotonic non-decreasing between clears. A verification assertion checks this.

Test Plan:
- Reset, then cov_valid=1, cov_hit=0x0000_0000_0000_00F0 in cycle 5 -> cov_sum=4 from cycle 8; new_hit=1 in cycle 7 only.
- Same vector repeated cycles 5..20 -> cov_sum stays 4; new_hit pulses once; cov_valid=0 with cov_hit=all-ones in cycle 21 -> no change.
- All-ones in cycle 5 then 0x1 in cycle 6 -> cov_sum=64 and stays 64; clear in cycle 30 -> cov_sum=0 in cycle 31; re-present 0x1 in cycle 32 -> cov_sum=1 in cycle 35.
- Snapshot: hits 0x3 in cycle 10, snap_req cycle 10, hits 0xC cycle 11 -> snap_ack cycle 13 with snap_sum=2; cov_sum=4 in cycle 14; snap_req in cycle 11 ignored (single ack).
- Saturation with COV_WIDTH=6, NUM_POINTS=64: all-ones in one cycle -> cov_sum=63, saturated=1; clear -> saturated=0.
- clear in cycle 12 during snapshot requested in cycle 10 -> no snap_ack through cycle 20; async reset asserted mid-cycle while hits flow -> all outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/cov_sum_accum.sv
// Unique-coverage accumulator: sticky seen bitmap, first-hit popcount pipeline,
// saturating running total and a drained snapshot handshake for round end.
module cov_sum_accum #(
    parameter int NUM_POINTS = 64,
    parameter int COV_WIDTH  = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cov_valid,
    input  logic [NUM_POINTS-1:0] cov_hit,
    input  logic                  clear,
    input  logic                  snap_req,
    output logic                  snap_ack,
    output logic [COV_WIDTH-1:0]  snap_sum,
    output logic [COV_WIDTH-1:0]  cov_sum,
    output logic                  new_hit,
    output logic                  saturated
);

    // state  | meaning
    // IDLE   | waiting for snap_req
    // DRAIN1 | hits from the request cycle moving through S2
    // DRAIN2 | request-cycle hits land in S3; snap_sum captured on exit
    // ACK    | snap_ack high, snap_sum valid
    typedef enum logic [1:0] {IDLE, DRAIN1, DRAIN2, ACK} snap_state_t;

    localparam int CNT_W = $clog2(NUM_POINTS + 1);
    localparam int SUM_W = ((COV_WIDTH > CNT_W) ? COV_WIDTH : CNT_W) + 1;
    localparam logic [COV_WIDTH-1:0] SUM_MAX = '1;

    logic [NUM_POINTS-1:0] seen;
    logic [NUM_POINTS-1:0] new_mask;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      pop;
    logic [3:0]            byte_pop;
    logic [SUM_W-1:0]      sum_wide;
    logic [COV_WIDTH-1:0]  sum_next;
    snap_state_t           state, state_next;
    logic                  capture;

    // S1: first-time hits only; hits in a clear cycle are dropped entirely
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen     <= '0;
            new_mask <= '0;
        end else if (clear) begin
            seen     <= '0;
            new_mask <= '0;
        end else if (cov_valid) begin
            seen     <= seen | cov_hit;
            new_mask <= cov_hit & ~seen;
        end else begin
            new_mask <= '0;
        end
    end

    // S2: popcount as a sum of byte popcounts
    always_comb begin
        pop      = '0;
        byte_pop = '0;
        for (int b = 0; b < NUM_POINTS / 8; b++) begin
            byte_pop = '0;
            for (int i = 0; i < 8; i++) begin
                byte_pop = byte_pop + {3'b000, new_mask[b*8+i]};
            end
            pop = pop + CNT_W'(byte_pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)      cnt <= '0;
        else if (clear) cnt <= '0;
        else            cnt <= pop;
    end

    assign new_hit = |cnt;

    // S3: saturating accumulate; sum_wide is wide enough that cnt never wraps it
    always_comb begin
        sum_wide = SUM_W'(cov_sum) + SUM_W'(cnt);
        sum_next = (sum_wide > SUM_W'(SUM_MAX)) ? SUM_MAX : sum_wide[COV_WIDTH-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cov_sum   <= '0;
            saturated <= 1'b0;
        end else if (clear) begin
            cov_sum   <= '0;
            saturated <= 1'b0;
        end else begin
            cov_sum   <= sum_next;
            saturated <= saturated | (sum_next == SUM_MAX);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (snap_req) state_next = DRAIN1;
                DRAIN1:  state_next = DRAIN2;
                DRAIN2:  state_next = ACK;
                ACK:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        snap_ack = (state == ACK);
        capture  = (state == DRAIN2) && !clear;
    end

    // Capture the value S3 is about to register so snap_sum is valid alongside the ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        snap_sum <= '0;
        else if (capture) snap_sum <= sum_next;
    end

    mono_chk: assert property (@(posedge clock) disable iff (reset)
        !clear |=> (cov_sum >= $past(cov_sum)));

endmodule

// File: tb/tb_cov_sum_accum.sv
// Directed bench for cov_sum_accum: default instance plus a COV_WIDTH=6 instance
// sharing the same stimulus for the saturation case.
module tb_cov_sum_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        cov_valid;
    logic [63:0] cov_hit;
    logic        clear;
    logic        snap_req;
    logic        snap_ack;
    logic [29:0] snap_sum;
    logic [29:0] cov_sum;
    logic        new_hit;
    logic        saturated;
    logic        sat_snap_ack;
    logic [5:0]  sat_snap_sum;
    logic [5:0]  sat_cov_sum;
    logic        sat_new_hit;
    logic        sat_saturated;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int acks   = 0;
    int pulses = 0;

    always #5 clock = ~clock;

    cov_sum_accum #(.NUM_POINTS(64), .COV_WIDTH(30)) dut (
        .clock(clock), .reset(reset), .cov_valid(cov_valid), .cov_hit(cov_hit),
        .clear(clear), .snap_req(snap_req), .snap_ack(snap_ack), .snap_sum(snap_sum),
        .cov_sum(cov_sum), .new_hit(new_hit), .saturated(saturated)
    );

    cov_sum_accum #(.NUM_POINTS(64), .COV_WIDTH(6)) dut_sat (
        .clock(clock), .reset(reset), .cov_valid(cov_valid), .cov_hit(cov_hit),
        .clear(clear), .snap_req(snap_req), .snap_ack(sat_snap_ack), .snap_sum(sat_snap_sum),
        .cov_sum(sat_cov_sum), .new_hit(sat_new_hit), .saturated(sat_saturated)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [63:0] h, input logic c, input logic r);
        cov_valid = v;
        cov_hit   = h;
        clear     = c;
        snap_req  = r;
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        acks   += int'(snap_ack);
        pulses += int'(new_hit);
    endtask

    initial begin
        drive(0, 64'h0, 0, 0);
        reset = 1'b1;
        #12 reset = 1'b0;
        @(posedge clock);
        #1;
        cyc = 0;
        chk("rst_cov_sum", 64'(cov_sum), 64'h0);
        chk("rst_snap_sum", 64'(snap_sum), 64'h0);
        chk("rst_snap_ack", 64'(snap_ack), 64'h0);
        chk("rst_new_hit", 64'(new_hit), 64'h0);
        chk("rst_saturated", 64'(saturated), 64'h0);

        // Same vector repeated: counted once, one new_hit pulse
        while (cyc < 5) tick();
        drive(1, 64'hF0, 0, 0);
        pulses = 0;
        tick();
        chk("c6_cov_sum", 64'(cov_sum), 64'h0);
        chk("c6_new_hit", 64'(new_hit), 64'h0);
        tick();
        chk("c7_new_hit", 64'(new_hit), 64'h1);
        chk("c7_cov_sum", 64'(cov_sum), 64'h0);
        tick();
        chk("c8_cov_sum", 64'(cov_sum), 64'h4);
        chk("c8_new_hit", 64'(new_hit), 64'h0);
        while (cyc < 21) tick();
        chk("c21_cov_sum", 64'(cov_sum), 64'h4);
        drive(0, '1, 0, 0);
        tick();
        drive(0, 64'h0, 0, 0);
        while (cyc < 25) tick();
        chk("invalid_ignored", 64'(cov_sum), 64'h4);
        chk("single_pulse", 64'(pulses), 64'h1);

        // All-ones then a duplicate, saturation on the narrow instance
        drive(0, 64'h0, 1, 0);
        tick();
        chk("c26_clear", 64'(cov_sum), 64'h0);
        chk("c26_sat_clear", 64'(sat_cov_sum), 64'h0);
        drive(1, '1, 0, 0);
        tick();
        drive(1, 64'h1, 0, 0);
        tick();
        drive(0, 64'h0, 0, 0);
        tick();
        chk("allones_sum", 64'(cov_sum), 64'd64);
        chk("sat_sum", 64'(sat_cov_sum), 64'd63);
        chk("sat_flag", 64'(sat_saturated), 64'h1);
        chk("wide_not_sat", 64'(saturated), 64'h0);
        tick();
        chk("dup_no_add", 64'(cov_sum), 64'd64);
        chk("c30_cyc", 64'(cyc), 64'd30);

        // Clear with hits in the same cycle: those hits are dropped
        drive(1, 64'h3, 1, 0);
        tick();
        chk("c31_cleared", 64'(cov_sum), 64'h0);
        chk("c31_sat_flag", 64'(sat_saturated), 64'h0);
        chk("c31_sat_sum", 64'(sat_cov_sum), 64'h0);
        drive(0, 64'h0, 0, 0);
        tick();
        drive(1, 64'h1, 0, 0);
        tick();
        drive(0, 64'h0, 0, 0);
        tick();
        chk("c34_cov_sum", 64'(cov_sum), 64'h0);
        tick();
        chk("c35_cov_sum", 64'(cov_sum), 64'h1);
        drive(1, 64'h2, 0, 0);
        tick();
        drive(0, 64'h0, 0, 0);
        tick();
        tick();
        chk("clear_hits_not_seen", 64'(cov_sum), 64'h2);

        // Snapshot handshake
        drive(0, 64'h0, 1, 0);
        tick();
        drive(0, 64'h0, 0, 0);
        chk("c39_cleared", 64'(cov_sum), 64'h0);
        tick();
        acks = 0;
        drive(1, 64'h3, 0, 1);
        tick();
        chk("snap_b1_ack", 64'(snap_ack), 64'h0);
        drive(1, 64'hC, 0, 1);
        tick();
        chk("snap_b2_ack", 64'(snap_ack), 64'h0);
        drive(0, 64'h0, 0, 0);
        tick();
        chk("snap_ack", 64'(snap_ack), 64'h1);
        chk("snap_sum", 64'(snap_sum), 64'h2);
        chk("snap_cov_sum", 64'(cov_sum), 64'h2);
        tick();
        chk("snap_ack_pulse", 64'(snap_ack), 64'h0);
        chk("post_snap_cov_sum", 64'(cov_sum), 64'h4);
        while (cyc < 48) tick();
        chk("single_ack", 64'(acks), 64'h1);
        chk("snap_sum_held", 64'(snap_sum), 64'h2);

        // Clear aborts an in-flight snapshot; request with clear is ignored
        while (cyc < 50) tick();
        acks = 0;
        drive(1, 64'hF00, 0, 1);
        tick();
        drive(0, 64'h0, 0, 0);
        tick();
        drive(0, 64'h0, 1, 0);
        tick();
        chk("abort_cov_sum", 64'(cov_sum), 64'h0);
        drive(0, 64'h0, 1, 1);
        tick();
        drive(0, 64'h0, 0, 0);
        while (cyc < 60) tick();
        chk("abort_no_ack", 64'(acks), 64'h0);
        chk("abort_snap_sum", 64'(snap_sum), 64'h2);
        chk("abort_cov_sum_end", 64'(cov_sum), 64'h0);

        // Asynchronous reset while hits and a snapshot are in flight
        while (cyc < 62) tick();
        drive(1, 64'hFF, 0, 0);
        tick();
        drive(1, 64'hFF00, 0, 0);
        tick();
        drive(1, 64'hFF0000, 0, 1);
        tick();
        chk("pre_rst_cov_sum", 64'(cov_sum), 64'd8);
        chk("pre_rst_new_hit", 64'(new_hit), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_cov_sum", 64'(cov_sum), 64'h0);
        chk("arst_new_hit", 64'(new_hit), 64'h0);
        chk("arst_snap_sum", 64'(snap_sum), 64'h0);
        chk("arst_snap_ack", 64'(snap_ack), 64'h0);
        chk("arst_saturated", 64'(saturated), 64'h0);
        drive(0, 64'h0, 0, 0);
        #10 reset = 1'b0;
        acks = 0;
        repeat (4) tick();
        chk("arst_no_ack", 64'(acks), 64'h0);
        chk("arst_idle_sum", 64'(cov_sum), 64'h0);
        drive(1, 64'hFF, 0, 0);
        tick();
        drive(0, 64'h0, 0, 0);
        tick();
        tick();
        chk("arst_seen_cleared", 64'(cov_sum), 64'd8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
